lcd_bus_receiver: RTL and testbench

LCD_BUS_RECEIVER -- requirements
Module: lcd_bus_receiver

---
 rtl/lcd_bus_receiver.sv | 188 ++++++++++++++++++
 tb/tb_lcd_bus_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_bus_receiver.sv
// HD44780-style LCD bus receiver: samples the asynchronous 4/8-bit bus,
// reassembles bytes, and emulates the busy flag and address counter so
// that a driver can read them back.
module lcd_bus_receiver #(
  parameter int unsigned BUSY_CYCLES = 2000,
  parameter int unsigned BUSY_LONG   = 82000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       LCD_E,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [3:0] LCD_DataIn,
  output logic [3:0] LCD_DataOut,
  output logic       LCD_DataOE,
  output logic [7:0] Byte_Out,
  output logic       Byte_RS,
  output logic       Byte_Valid,
  output logic       Busy,
  output logic [6:0] Addr,
  output logic       Mode4,
  output logic       Proto_Err,
  output logic [1:0] state_dbg
);

  // INIT8: one strobe per byte (8-bit init phase); HI/LO: nibble pairs.
  typedef enum logic [1:0] {
    INIT8 = 2'd0,
    HI    = 2'd1,
    LO    = 2'd2
  } state_t;

  state_t      state;

  logic        e_m, e_s, e_q;
  logic        rs_m, rs_s, rw_m, rw_s;
  logic [3:0]  d_m, d_s;
  logic        lat_rs, lat_rw;
  logic [3:0]  lat_nib;

  logic [3:0]  hi_nib;
  logic        hi_rs, hi_rw;
  logic [3:0]  rd_lo;
  logic [31:0] busy_cnt;

  logic        strobe;
  logic        emit;
  logic [7:0]  emit_byte;
  logic        emit_long;
  logic [31:0] busy_load;

  // Two-flop synchronizers for the bus, plus a latch of RS/RW/data while E is high
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      e_m     <= 1'b0;
      e_s     <= 1'b0;
      e_q     <= 1'b0;
      rs_m    <= 1'b0;
      rs_s    <= 1'b0;
      rw_m    <= 1'b0;
      rw_s    <= 1'b0;
      d_m     <= 4'h0;
      d_s     <= 4'h0;
      lat_rs  <= 1'b0;
      lat_rw  <= 1'b0;
      lat_nib <= 4'h0;
    end else begin
      e_m  <= LCD_E;
      e_s  <= e_m;
      e_q  <= e_s;
      rs_m <= LCD_RS;
      rs_s <= rs_m;
      rw_m <= LCD_RW;
      rw_s <= rw_m;
      d_m  <= LCD_DataIn;
      d_s  <= d_m;
      if (e_s) begin
        lat_rs  <= rs_s;
        lat_rw  <= rw_s;
        lat_nib <= d_s;
      end
    end
  end

  // Falling edge of synchronized E; the latched values belong to this strobe.
  assign strobe      = e_q & ~e_s;
  assign Busy        = (busy_cnt != 32'd0);
  assign LCD_DataOE  = e_s & rw_s;
  // High nibble is live status; the low nibble comes from the snapshot taken at the high strobe.
  assign LCD_DataOut = (state == LO) ? rd_lo : {Busy, Addr[6:4]};
  assign state_dbg   = state;

  // Decide whether this strobe completes a write byte, and what that byte is
  always_comb begin
    emit      = 1'b0;
    emit_byte = {lat_nib, 4'h0};
    if (strobe && !lat_rw) begin
      if (state == INIT8) begin
        emit = 1'b1;
      end else if (state == LO && !hi_rw && (lat_rs == hi_rs)) begin
        emit      = 1'b1;
        emit_byte = {hi_nib, lat_nib};
      end
    end
    emit_long = !lat_rs && (emit_byte >= 8'h01) && (emit_byte <= 8'h03);
    busy_load = emit_long ? BUSY_LONG : BUSY_CYCLES;
  end

  // Nibble sequencing FSM with byte output, address counter and busy counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= INIT8;
      hi_nib     <= 4'h0;
      hi_rs      <= 1'b0;
      hi_rw      <= 1'b0;
      rd_lo      <= 4'h0;
      busy_cnt   <= 32'd0;
      Byte_Out   <= 8'h00;
      Byte_RS    <= 1'b0;
      Byte_Valid <= 1'b0;
      Addr       <= 7'h00;
      Mode4      <= 1'b0;
      Proto_Err  <= 1'b0;
    end else begin
      Byte_Valid <= 1'b0;
      Proto_Err  <= 1'b0;
      if (Busy) begin
        busy_cnt <= busy_cnt - 32'd1;
      end
      if (strobe) begin
        case (state)
          INIT8: begin
            // Function set with DL=0 switches the bus to nibble pairs.
            if (!lat_rw && !lat_rs && lat_nib == 4'h2) begin
              state <= HI;
              Mode4 <= 1'b1;
            end
          end
          HI: begin
            hi_nib <= lat_nib;
            hi_rs  <= lat_rs;
            hi_rw  <= lat_rw;
            if (lat_rw) begin
              rd_lo <= Addr[3:0];
            end
            state <= LO;
          end
          LO: begin
            if (lat_rw != hi_rw) begin
              Proto_Err <= 1'b1;
              state     <= HI;
            end else if (lat_rw) begin
              state <= HI;
            end else if (lat_rs != hi_rs) begin
              // Mismatched RS: drop the old half and restart from this nibble.
              Proto_Err <= 1'b1;
              hi_nib    <= lat_nib;
              hi_rs     <= lat_rs;
            end else if (!lat_rs && hi_nib == 4'h3) begin
              // Function set with DL=1 drops back to 8-bit.
              state <= INIT8;
              Mode4 <= 1'b0;
            end else begin
              state <= HI;
            end
          end
          default: state <= INIT8;
        endcase
      end
      if (emit) begin
        Byte_Out   <= emit_byte;
        Byte_RS    <= lat_rs;
        Byte_Valid <= 1'b1;
        Proto_Err  <= Busy;
        // Placed after the decrement so a reload wins over expiry.
        busy_cnt   <= busy_load;
        if (lat_rs) begin
          Addr <= Addr + 7'd1;
        end else if (emit_long) begin
          Addr <= 7'h00;
        end else if (emit_byte[7]) begin
          Addr <= emit_byte[6:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed steps followed by random nibble traffic,
// each strobe checked against a nibble-pairing reference model.
module tb_lcd_bus_receiver;

  localparam int NB = 40;
  localparam int NL = 100;

  logic       Clk, Rst;
  logic       LCD_E, LCD_RS, LCD_RW;
  logic [3:0] LCD_DataIn;
  logic [3:0] LCD_DataOut;
  logic       LCD_DataOE;
  logic [7:0] Byte_Out;
  logic       Byte_RS, Byte_Valid, Busy;
  logic [6:0] Addr;
  logic       Mode4, Proto_Err;
  logic [1:0] state_dbg;

  lcd_bus_receiver #(.BUSY_CYCLES(NB), .BUSY_LONG(NL)) dut (
    .Clk(Clk), .Rst(Rst),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_DataIn(LCD_DataIn),
    .LCD_DataOut(LCD_DataOut), .LCD_DataOE(LCD_DataOE),
    .Byte_Out(Byte_Out), .Byte_RS(Byte_RS), .Byte_Valid(Byte_Valid),
    .Busy(Busy), .Addr(Addr), .Mode4(Mode4), .Proto_Err(Proto_Err),
    .state_dbg(state_dbg)
  );

  // Clock and cycle counter
  int cyc = 0;
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, cyc=%0d", cyc);
    $fatal(1);
  end

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit         m_four;
  logic [6:0] m_addr;
  int         busy_end;
  logic [5:0] pend_q[$];
  logic [7:0] rd_cap;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_four   = 1'b0;
    m_addr   = 7'h00;
    busy_end = 0;
    rd_cap   = 8'h00;
    pend_q.delete();
  endtask

  // A completed write byte: address rules, busy reload, expected output.
  task automatic model_emit(input logic [7:0] b, input logic rs, input int k, input bit busy_s,
                            output bit perr);
    int len;
    len = (!rs && b >= 1 && b <= 3) ? NL : NB;
    if (rs) m_addr = m_addr + 7'd1;
    else if (b >= 1 && b <= 3) m_addr = 7'h00;
    else if (b >= 128) m_addr = 7'(b - 128);
    busy_end = k + 3 + len;
    perr = busy_s;
    exp_q.push_back({rs, b});
  endtask

  task automatic model_strobe(input logic rw, input logic rs, input logic [3:0] nib, input int k,
                              output bit e_valid, output bit e_perr);
    bit busy_s;
    logic [5:0] p;
    busy_s  = (k + 2) < busy_end;
    e_valid = 1'b0;
    e_perr  = 1'b0;
    if (!m_four) begin
      if (!rw) begin
        e_valid = 1'b1;
        model_emit({nib, 4'h0}, rs, k, busy_s, e_perr);
        if (!rs && nib == 4'h2) m_four = 1'b1;
      end
    end else if (pend_q.size() == 0) begin
      pend_q.push_back({rw, rs, nib});
      if (rw) rd_cap = {busy_s, m_addr};
    end else begin
      p = pend_q.pop_front();
      if (p[5] != rw) begin
        e_perr = 1'b1;
      end else if (!rw) begin
        if (p[4] != rs) begin
          e_perr = 1'b1;
          pend_q.push_back({rw, rs, nib});
        end else begin
          e_valid = 1'b1;
          model_emit({p[3:0], nib}, rs, k, busy_s, e_perr);
          if (!rs && p[3:0] == 4'h3) m_four = 1'b0;
        end
      end
    end
  endtask

  // Driver: one E pulse carrying a nibble, followed by a check of all outputs
  task automatic do_strobe(input logic rw, input logic rs, input logic [3:0] nib);
    int k, nv, np, voff;
    logic [7:0] vb;
    logic vr, oe_obs;
    logic [3:0] rd_obs, rd_exp;
    bit e_valid, e_perr;
    @(negedge Clk);
    LCD_RS = rs; LCD_RW = rw; LCD_DataIn = nib;
    @(negedge Clk);
    LCD_E = 1'b1;
    repeat (4) @(negedge Clk);
    rd_obs = LCD_DataOut;
    oe_obs = LCD_DataOE;
    if (m_four && pend_q.size() != 0) rd_exp = rd_cap[3:0];
    else rd_exp = {cyc < busy_end, m_addr[6:4]};
    LCD_E = 1'b0;
    k = cyc;
    nv = 0; np = 0; voff = 0; vb = 8'h00; vr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (Byte_Valid) begin
        nv++; vb = Byte_Out; vr = Byte_RS; voff = cyc - k;
      end
      if (Proto_Err) np++;
    end
    model_strobe(rw, rs, nib, k, e_valid, e_perr);
    check("valid_count", nv, e_valid);
    if (nv != 0 && exp_q.size() != 0) begin
      check("byte_rs_out", {vr, vb}, exp_q.pop_front());
      check("valid_latency", voff, 3);
    end
    check("proto_err_count", np, e_perr);
    check("addr", Addr, m_addr);
    check("mode4", Mode4, m_four);
    check("busy", Busy, cyc < busy_end);
    check("oe_after_e", LCD_DataOE, 1'b0);
    if (rw) begin
      check("read_nibble", rd_obs, rd_exp);
      check("oe_read", oe_obs, 1'b1);
    end else begin
      check("oe_write", oe_obs, 1'b0);
    end
  endtask

  task automatic wait_idle();
    while (cyc < busy_end) @(negedge Clk);
  endtask

  task automatic busy_fall();
    int n;
    n = 0;
    while (Busy === 1'b1 && n < 4 * NL) begin
      @(negedge Clk);
      n++;
    end
    check("busy_fall_cycle", cyc, busy_end);
  endtask

  task automatic check_reset_vals();
    check("rst_byte_out", Byte_Out, 8'h00);
    check("rst_byte_rs", Byte_RS, 1'b0);
    check("rst_byte_valid", Byte_Valid, 1'b0);
    check("rst_busy", Busy, 1'b0);
    check("rst_addr", Addr, 7'h00);
    check("rst_mode4", Mode4, 1'b0);
    check("rst_proto_err", Proto_Err, 1'b0);
    check("rst_data_out", LCD_DataOut, 4'h0);
    check("rst_data_oe", LCD_DataOE, 1'b0);
  endtask

  logic rs_r, rw_r;

  // Directed steps, then randomized traffic, then the summary
  initial begin
    Rst = 1'b0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_DataIn = 4'h0;
    model_reset();
    repeat (3) @(negedge Clk);
    check_reset_vals();
    Rst = 1'b1;
    repeat (2) @(negedge Clk);

    // 8-bit init sequence ending in 4-bit mode
    do_strobe(0, 0, 4'h3); wait_idle();
    do_strobe(0, 0, 4'h3); wait_idle();
    do_strobe(0, 0, 4'h3); wait_idle();
    do_strobe(0, 0, 4'h2); wait_idle();
    check("mode4_after_init", Mode4, 1'b1);

    // Data 0x41, busy window length
    do_strobe(0, 1, 4'h4);
    do_strobe(0, 1, 4'h1);
    busy_fall();

    // Read right after a byte (busy set), then after the busy time
    do_strobe(0, 1, 4'h4);
    do_strobe(0, 1, 4'h2);
    do_strobe(1, 0, 4'h0);
    do_strobe(1, 0, 4'h0);
    wait_idle();
    do_strobe(1, 0, 4'h0);
    do_strobe(1, 0, 4'h0);

    // Address wrap: 0xFF command then data
    wait_idle();
    do_strobe(0, 0, 4'hF); do_strobe(0, 0, 4'hF);
    wait_idle();
    do_strobe(0, 1, 4'h7); do_strobe(0, 1, 4'hA);

    // Clear: address zero and long busy
    wait_idle();
    do_strobe(0, 0, 4'h0); do_strobe(0, 0, 4'h1);
    busy_fall();

    // RS mismatch, then completion with the new high nibble
    wait_idle();
    do_strobe(0, 1, 4'h4); do_strobe(0, 0, 4'h1);
    do_strobe(0, 0, 4'h0);

    // Direction change between nibbles, then a clean byte
    wait_idle();
    do_strobe(0, 1, 4'h4); do_strobe(1, 1, 4'h2);
    do_strobe(0, 1, 4'h4); do_strobe(0, 1, 4'h2);

    // Write while busy still processed
    do_strobe(0, 1, 4'h4); do_strobe(0, 1, 4'h3);

    // DL=1 command returns to 8-bit, then back to 4-bit
    wait_idle();
    do_strobe(0, 0, 4'h3); do_strobe(0, 0, 4'h8);
    wait_idle();
    do_strobe(0, 0, 4'h2);

    // Reset mid-byte while busy
    do_strobe(0, 1, 4'h5); do_strobe(0, 1, 4'h5);
    do_strobe(0, 1, 4'h6);
    @(negedge Clk);
    #2 Rst = 1'b0;
    #1 check_reset_vals();
    model_reset();
    @(negedge Clk);
    Rst = 1'b1;
    @(negedge Clk);
    do_strobe(0, 0, 4'h3);
    wait_idle();
    do_strobe(0, 0, 4'h2);

    // Random traffic
    rs_r = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if ($urandom_range(0, 3) == 0) rs_r = ~rs_r;
      rw_r = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 1) == 0) wait_idle();
      do_strobe(rw_r, rs_r, 4'($urandom_range(0, 15)));
    end

    check("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
